serial_frame_rx: RTL and testbench

- Serial-to-parallel frame receiver that sits directly downstream of the enable D flip-flop.
- The flip-flop's registered output drives i_d, and its enable strobe drives i_en.
- The block deframes start / data / parity / stop bits into a WIDTH-bit word.
- The word is presented on a valid/ready output register; parity, framing and overrun errors are flagged.

---
 rtl/serial_frame_rx.sv | 151 +++++++++++++++
 tb/tb_serial_frame_rx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Deframes a strobed serial bit stream (start, WIDTH data bits LSB-first,
//   optional even-parity bit, stop) into a parallel word held in a
//   valid/ready output register.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_d           serial data bit, sampled only when i_en=1
//   i_en          bit strobe; no frame state moves while it is low
//   o_data        received word, stable while o_valid=1
//   o_valid       o_data holds an unconsumed word
//   i_ready       consumer accepts o_data on an edge with o_valid & i_ready
//   o_parity_err  parity verdict for the word in o_data
//   o_frame_err   one-cycle pulse after a stop bit sampled as 0
//   o_overrun     sticky: a good frame was dropped because o_data was full
//   o_busy        receiver is mid-frame
//
// State    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line idle, waiting for a 0 start bit
// S_DATA   | shifting in WIDTH data bits, LSB first
// S_PARITY | sampling the even-parity bit (only when PARITY_EN=1)
// S_STOP   | sampling the stop bit; commit, drop or flag framing error

module serial_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_d,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_overrun,
  output logic             o_busy
);

  // Counter must be able to hold WIDTH after the last data bit.
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             par_q;       // running XOR of data bits in flight
  logic             perr_q;      // parity verdict of the frame in flight
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             perr_out_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             out_free_d;

  // Right shift with the new bit entering at the MSB: after WIDTH bits the
  // first received bit sits in bit 0. Written this way so WIDTH=1 works.
  always_comb begin
    shift_d            = shift_q >> 1;
    shift_d[WIDTH-1]   = i_d;
  end

  // The output register can take a new word if it is empty or is being
  // drained on this same edge.
  assign out_free_d = !valid_q || i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_out_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;

      // Consume first; a commit later in this block overrides it.
      if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end

      if (i_en) begin
        case (state_q)
          S_IDLE: begin
            if (!i_d) begin
              state_q <= S_DATA;
              cnt_q   <= '0;
              par_q   <= 1'b0;
              perr_q  <= 1'b0;
            end
          end

          S_DATA: begin
            shift_q <= shift_d;
            par_q   <= par_q ^ i_d;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_q <= PARITY_EN ? S_PARITY : S_STOP;
            end
          end

          S_PARITY: begin
            perr_q  <= par_q ^ i_d;
            state_q <= S_STOP;
          end

          S_STOP: begin
            state_q <= S_IDLE;
            if (i_d) begin
              if (out_free_d) begin
                data_q     <= shift_q;
                perr_out_q <= perr_q;
                valid_q    <= 1'b1;
              end else begin
                overrun_q  <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = frame_err_q;
  assign o_overrun    = overrun_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         d;
  logic         en;
  logic         ready;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         o_parity_err;
  logic         o_frame_err;
  logic         o_overrun;
  logic         o_busy;

  serial_frame_rx #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_d          (d),
    .i_en         (en),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (ready),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         perr;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Inputs change on the falling edge; outputs are all registered so they
  // can be sampled at the same falling edge.
  task automatic drive_bit(input logic b, input logic v);
    @(negedge clk);
    d  = b;
    en = v;
  endtask

  task automatic idle_cycle();
    drive_bit(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] data, input logic par, input logic stop);
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < W; i++) drive_bit(data[i], 1'b1);
    drive_bit(par, 1'b1);
    drive_bit(stop, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; d = 1'b0; en = 1'b1; ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
               o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy);
    end
    rst = 1'b0; d = 1'b1; en = 1'b0; ready = 1'b1;
    idle_cycle();
  endtask

  task automatic test_basic();
    sb.push_back(exp_t'{data: 8'hA5, perr: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_cycle();
    checks++;
    if (o_valid !== 1'b1) begin
      failures++; $display("FAIL basic_valid: got %b expected 1", o_valid);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL basic_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if (o_data !== e.data || o_parity_err !== e.perr) begin
        failures++;
        $display("FAIL basic_data: got %h/%b expected %h/%b", o_data, o_parity_err, e.data, e.perr);
      end
    end
    checks++;
    if (o_frame_err !== 1'b0) begin
      failures++; $display("FAIL basic_frame_err: got %b expected 0", o_frame_err);
    end
    idle_cycle();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++; $display("FAIL basic_valid_one_cycle: got %b expected 0", o_valid);
    end
  endtask

  task automatic test_parity_err();
    sb.push_back(exp_t'{data: 8'hA5, perr: 1'b1});
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_cycle();
    checks++;
    if (o_valid !== 1'b1) begin
      failures++; $display("FAIL perr_valid: got %b expected 1", o_valid);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL perr_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if (o_data !== e.data || o_parity_err !== e.perr) begin
        failures++;
        $display("FAIL perr_data: got %h/%b expected %h/%b", o_data, o_parity_err, e.data, e.perr);
      end
    end
    idle_cycle();
  endtask

  task automatic test_sparse_en();
    logic [10:0] fb;
    int busy_bad;
    fb = {1'b1, 1'b0, 8'hA5, 1'b0};
    busy_bad = 0;
    sb.push_back(exp_t'{data: 8'hA5, perr: 1'b0});
    for (int k = 0; k < 11; k++) begin
      drive_bit(fb[k], 1'b1);
      if (k < 10) begin
        drive_bit(~fb[k], 1'b0);
        checks++;
        if (o_busy !== 1'b1) begin
          failures++; $display("FAIL sparse_busy bit%0d: got %b expected 1", k, o_busy);
        end
      end
    end
    idle_cycle();
    checks++;
    if (o_valid !== 1'b1 || o_busy !== 1'b0) begin
      failures++; $display("FAIL sparse_done: got valid=%b busy=%b expected 1/0", o_valid, o_busy);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL sparse_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if (o_data !== e.data || o_parity_err !== e.perr) begin
        failures++;
        $display("FAIL sparse_data: got %h/%b expected %h/%b", o_data, o_parity_err, e.data, e.perr);
      end
    end
    idle_cycle();
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    sb.push_back(exp_t'{data: 8'h3C, perr: 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    idle_cycle();
    checks++;
    if (o_valid !== 1'b1 || o_overrun !== 1'b1) begin
      failures++; $display("FAIL overrun_flags: got valid=%b ovr=%b expected 1/1", o_valid, o_overrun);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL overrun_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if (o_data !== e.data || o_parity_err !== e.perr) begin
        failures++;
        $display("FAIL overrun_data: got %h/%b expected %h/%b", o_data, o_parity_err, e.data, e.perr);
      end
    end
    ready = 1'b1;
    idle_cycle();
    checks++;
    if (o_valid !== 1'b0 || o_overrun !== 1'b1) begin
      failures++; $display("FAIL overrun_drain: got valid=%b ovr=%b expected 0/1", o_valid, o_overrun);
    end
  endtask

  task automatic test_frame_err();
    ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    idle_cycle();
    checks++;
    if (o_frame_err !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_pulse: got fe=%b valid=%b busy=%b expected 1/0/0",
               o_frame_err, o_valid, o_busy);
    end
    idle_cycle();
    checks++;
    if (o_frame_err !== 1'b0) begin
      failures++; $display("FAIL frame_err_width: got %b expected 0", o_frame_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] junk;
    junk = 8'h96;
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive_bit(junk[i], 1'b1);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; d = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; d = 1'b1;
    checks++;
    if ({o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
               o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy);
    end
    sb.push_back(exp_t'{data: 8'h0F, perr: 1'b0});
    send_frame(8'h0F, 1'b0, 1'b1);
    idle_cycle();
    checks++;
    if (o_valid !== 1'b1) begin
      failures++; $display("FAIL midreset_valid: got %b expected 1", o_valid);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL midreset_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if (o_data !== e.data || o_parity_err !== e.perr) begin
        failures++;
        $display("FAIL midreset_data: got %h/%b expected %h/%b", o_data, o_parity_err, e.data, e.perr);
      end
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    localparam int NB = 4;
    logic [10:0]  fb [NB];
    logic [W-1:0] dat;
    logic         par;
    ready = 1'b1;
    for (int f = 0; f < NB; f++) begin
      dat   = W'($urandom);
      par   = 1'($urandom_range(0, 1));
      fb[f] = {1'b1, par, dat, 1'b0};
      sb.push_back(exp_t'{data: dat, perr: (^dat) ^ par});
    end
    for (int f = 0; f <= NB; f++) begin
      for (int k = 0; k < 11; k++) begin
        if (f < NB) drive_bit(fb[f][k], 1'b1);
        else if (k == 0) drive_bit(1'b1, 1'b0);
        else break;
        if (k == 0 && f > 0) begin
          checks++;
          if (o_valid !== 1'b1) begin
            failures++; $display("FAIL b2b_valid frame%0d: got %b expected 1", f - 1, o_valid);
          end
          checks++;
          if (sb.size() == 0) begin
            failures++; $display("FAIL b2b_sb frame%0d: got empty queue expected entry", f - 1);
          end else begin
            e = sb.pop_front();
            if (o_data !== e.data || o_parity_err !== e.perr) begin
              failures++;
              $display("FAIL b2b_data frame%0d: got %h/%b expected %h/%b",
                       f - 1, o_data, o_parity_err, e.data, e.perr);
            end
          end
        end
      end
    end
    idle_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_sparse_en();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
